seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The module SHALL have parameter DATAWIDTH, default 8: operand and result width in bits, legal range 2 or more.
REQ-002 The module SHALL have parameter SHAMTWIDTH, default 4: shift-amount width in bits, legal range 1 or more.
REQ-003 The module SHALL have parameter STEP, default 2: maximum bit positions shifted per clock, legal range 1 to DATAWIDTH.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request strobe, sampled only in IDLE.
REQ-007 a  input  DATAWIDTH, signed  operand.
REQ-008 sh_amt  input  SHAMTWIDTH, unsigned  requested shift distance.
REQ-009 mode  input  2  operation select: 00 LSR (logical right), 01 ASR (arithmetic right), 10 LSL (logical left), 11 ROR (rotate right).
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking a valid new result.
REQ-012 d  output  DATAWIDTH, signed, registered  result.

Function
REQ-013 The block SHALL implement a 2-state FSM: IDLE and SHIFT.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture a, mode and the effective amount E into internal registers, then enter SHIFT.
REQ-015 Effective amount E: for ROR, sh_amt mod DATAWIDTH; for LSR/ASR/LSL, min(sh_amt, DATAWIDTH).
REQ-016 Each SHIFT cycle with remaining R>0: shift the working register by min(STEP,R) per mode, then decrement R by that amount.
REQ-017 Fill rules: LSR and LSL fill with 0; ASR fills with the captured sign bit a[DATAWIDTH-1]; ROR wraps bit 0 into the MSB.
REQ-018 In SHIFT with R=0: load d with the working register, assert done, clear busy, return to IDLE.
REQ-019 Latency: done SHALL be high in the cycle following acceptance edge + K + 1 edges, where K = ceil(E/STEP); E=0 gives done one edge after acceptance.
REQ-020 busy SHALL be high from the acceptance edge up to, and not including, the edge that asserts done; busy and done SHALL never be high together.
REQ-021 done SHALL be high for exactly one cycle per accepted request.
REQ-022 start while busy=1 SHALL be ignored and not queued.
REQ-023 start held high continuously SHALL be accepted again in the first IDLE cycle after done, giving back-to-back operations.
REQ-024 Changes to a, sh_amt and mode after acceptance SHALL NOT affect the in-flight result.
REQ-025 d SHALL hold its last value between done pulses.

Reset
REQ-026 Rst=1 SHALL immediately, without waiting for Clk, force state IDLE, busy=0, done=0, d=0, and clear all working and remaining registers.
REQ-027 Rst asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after Rst deasserts SHALL be accepted normally.

Verification (DATAWIDTH=8, SHAMTWIDTH=4, STEP=2)
REQ-028 ASR test: a=8'h96, sh_amt=3, mode=01 -> E=3, K=2, done 3 edges after acceptance, d=8'hF2.
REQ-029 LSR test: a=8'h96, sh_amt=3, mode=00 -> d=8'h12, same latency as REQ-028. LSL overshoot test: sh_amt=9, mode=10 -> E=8, done 5 edges after acceptance, d=8'h00.
REQ-030 ROR wrap test: a=8'h96, sh_amt=11, mode=11 -> E=3, d=8'hD2, done 3 edges after acceptance.
REQ-031 Zero-shift and busy test: a=8'h5A, sh_amt=0 -> done 1 edge after acceptance, d=8'h5A. A second start pulsed while busy in the REQ-028 case -> ignored; exactly one done; d=8'hF2.
REQ-032 Reset test: Rst pulsed mid-SHIFT, asynchronous to Clk -> busy, done and d go to 0 before the next edge, no done pulse follows. A new LSR request (a=8'h80, sh_amt=1) -> d=8'h40.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: LSR/ASR/LSL/ROR, up to STEP positions per clock.
// Latency ceil(E/STEP)+1 edges after acceptance; start is ignored while busy.
module seq_shifter #(
  parameter int DATAWIDTH  = 8,
  parameter int SHAMTWIDTH = 4,
  parameter int STEP       = 2
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        start,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic [SHAMTWIDTH-1:0]       sh_amt,
  input  logic [1:0]                  mode,
  output logic                        busy,
  output logic                        done,
  output logic signed [DATAWIDTH-1:0] d
);

  localparam int RW = $clog2(DATAWIDTH + 1);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] work_q, work_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [1:0]           mode_q, mode_d;
  logic                 done_q, done_d;
  logic [DATAWIDTH-1:0] d_q, d_d;

  logic [31:0]          amt_ext;
  logic [31:0]          eff;
  logic [DATAWIDTH-1:0] shifted;
  logic [RW-1:0]        step_amt;

  function automatic logic [DATAWIDTH-1:0] shift1(input logic [DATAWIDTH-1:0] w,
                                                  input logic [1:0] m);
    case (m)
      MODE_LSR: shift1 = {1'b0, w[DATAWIDTH-1:1]};
      // MSB of the working register still holds the captured sign bit
      MODE_ASR: shift1 = {w[DATAWIDTH-1], w[DATAWIDTH-1:1]};
      MODE_LSL: shift1 = {w[DATAWIDTH-2:0], 1'b0};
      default:  shift1 = {w[0], w[DATAWIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    amt_ext = 32'(sh_amt);
    if (mode == 2'b11) begin
      eff = amt_ext % 32'(DATAWIDTH);
    end else begin
      eff = (amt_ext > 32'(DATAWIDTH)) ? 32'(DATAWIDTH) : amt_ext;
    end
  end

  always_comb begin
    shifted  = work_q;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(rem_q)) begin
        shifted = shift1(shifted, mode_q);
      end
    end
    step_amt = (int'(rem_q) > STEP) ? RW'(STEP) : rem_q;
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = a;
          mode_d  = mode;
          rem_d   = RW'(eff);
          state_d = SHIFT;
        end
      end
      default: begin
        if (rem_q == '0) begin
          d_d     = work_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          work_d = shifted;
          rem_d  = rem_q - step_amt;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      d_q     <= d_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign d    = d_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized and directed bench for seq_shifter against an arithmetic reference model.
module tb_seq_shifter;

  localparam int DW   = 8;
  localparam int SW   = 4;
  localparam int STEP = 2;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [DW-1:0] a;
  logic [SW-1:0] sh_amt;
  logic [1:0]    mode;
  logic          busy;
  logic          done;
  logic [DW-1:0] d;

  int total = 0;
  int bad   = 0;

  seq_shifter #(.DATAWIDTH(DW), .SHAMTWIDTH(SW), .STEP(STEP)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .a(a), .sh_amt(sh_amt),
    .mode(mode), .busy(busy), .done(done), .d(d)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result from the operation definitions; latency = ceil(E/STEP) + 1 edges.
  function automatic logic [DW-1:0] ref_res(input logic [DW-1:0] av, input int sv,
                                            input logic [1:0] mv, output int lat);
    int e;
    logic [2*DW-1:0] dbl;
    if (mv == 2'b11) e = sv % DW;
    else             e = (sv > DW) ? DW : sv;
    lat = (e + STEP - 1) / STEP + 1;
    dbl = {av, av};
    case (mv)
      2'b00:   ref_res = av >> e;
      2'b01:   ref_res = DW'($signed(av) >>> e);
      2'b10:   ref_res = av << e;
      default: ref_res = DW'(dbl >> e);
    endcase
  endfunction

  // Counts edges from the current point until done is seen (bounded).
  task automatic wait_done(output int n);
    bit seen;
    bit gap;
    n    = 0;
    seen = 0;
    gap  = 0;
    while (!seen && n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (done) seen = 1;
      else if (!busy) gap = 1;
    end
    chk("busy_gap", 32'(gap), 32'd0);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [DW-1:0] av, input logic [SW-1:0] sv,
                        input logic [1:0] mv, input bit pulse_busy);
    int lat, n, pre;
    logic [DW-1:0] exp;
    exp = ref_res(av, int'(sv), mv, lat);
    @(negedge Clk);
    a = av; sh_amt = sv; mode = mv; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    a = DW'($urandom); sh_amt = SW'($urandom); mode = 2'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    pre = 0;
    if (pulse_busy) begin
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      pre = 1;
      chk("busy_ignores_start", 32'(busy), 32'd1);
    end
    wait_done(n);
    chk("latency", 32'(n + pre), 32'(lat));
    chk("result", 32'(d), 32'(exp));
    @(posedge Clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("d_hold", 32'(d), 32'(exp));
    if (pulse_busy) begin
      repeat (6) begin
        @(posedge Clk); #1;
        chk("no_queued_op", 32'({busy, done}), 32'd0);
      end
    end
  endtask

  initial begin
    int n, lat_a, lat_b;
    logic [DW-1:0] exp_a, exp_b;
    Rst = 1'b1; start = 1'b0; a = '0; sh_amt = '0; mode = '0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_d", 32'(d), 32'd0);
    #11 Rst = 1'b0;

    run_op(8'h96, 4'd3, 2'b01, 1'b0);
    run_op(8'h96, 4'd3, 2'b00, 1'b0);
    run_op(8'h96, 4'd9, 2'b10, 1'b0);
    run_op(8'h96, 4'd11, 2'b11, 1'b0);
    run_op(8'h5A, 4'd0, 2'b00, 1'b0);
    run_op(8'h96, 4'd3, 2'b01, 1'b1);

    // Back-to-back with start held high; inputs change right after each acceptance.
    exp_a = ref_res(8'hC3, 5, 2'b11, lat_a);
    exp_b = ref_res(8'h81, 7, 2'b01, lat_b);
    @(negedge Clk);
    a = 8'hC3; sh_amt = 4'd5; mode = 2'b11; start = 1'b1;
    @(posedge Clk); #1;
    a = 8'h81; sh_amt = 4'd7; mode = 2'b01;
    wait_done(n);
    chk("b2b_lat_a", 32'(n), 32'(lat_a));
    chk("b2b_res_a", 32'(d), 32'(exp_a));
    @(posedge Clk); #1;
    chk("b2b_reaccept", 32'({busy, done}), 32'b10);
    start = 1'b0; a = 8'h00; sh_amt = 4'd0; mode = 2'b00;
    wait_done(n);
    chk("b2b_lat_b", 32'(n), 32'(lat_b));
    chk("b2b_res_b", 32'(d), 32'(exp_b));
    @(posedge Clk); #1;

    // Asynchronous reset in the middle of a shift.
    run_op(8'h96, 4'd3, 2'b01, 1'b0);
    @(negedge Clk);
    a = 8'h96; sh_amt = 4'd7; mode = 2'b01; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    #2 Rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_d", 32'(d), 32'd0);
    #2 Rst = 1'b0;
    repeat (6) begin
      @(posedge Clk); #1;
      chk("arst_no_done", 32'(done), 32'd0);
    end
    run_op(8'h80, 4'd1, 2'b00, 1'b0);
    chk("post_reset_lsr", 32'(d), 32'h40);

    for (int i = 0; i < 30; i++) begin
      run_op(DW'($urandom), SW'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
